// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS opcode/funct constants and source-use helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'd0;
    localparam logic [5:0]  OP_J     = 6'd2;
    localparam logic [5:0]  OP_JAL   = 6'd3;
    localparam logic [5:0]  OP_BEQ   = 6'd4;
    localparam logic [5:0]  OP_BNE   = 6'd5;
    localparam logic [5:0]  OP_LUI   = 6'd15;
    localparam logic [5:0]  OP_SW    = 6'd43;
    localparam logic [5:0]  FUNCT_JR = 6'd8;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    function automatic logic rs_is_used(input logic [5:0] op);
        return !(op == OP_J || op == OP_JAL || op == OP_LUI);
    endfunction

    function automatic logic rt_is_used(input logic [5:0] op);
        return (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW);
    endfunction

    // Instructions whose operands are consumed in ID rather than EX.
    function automatic logic is_redirect_type(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_BEQ || op == OP_BNE || (op == OP_RTYPE && funct == FUNCT_JR));
    endfunction

    function automatic logic src_hit(input logic [4:0] dest, input logic [4:0] src,
                                     input logic used);
        return used && (src != 5'd0) && (dest == src);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use and ID-stage branch-operand stall logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
    import mips_pkg::*;
#(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic       rs_used,
    input  logic       rt_used,
    input  logic [4:0] rs_addr,
    input  logic [4:0] rt_addr,
    input  logic       redirect_type,
    input  logic       id_ex_mem_read,
    input  logic       id_ex_reg_write,
    input  logic [4:0] id_ex_dest,
    input  logic       ex_mem_mem_read,
    input  logic [4:0] ex_mem_dest,
    output logic       stall
);

    logic w_ex_hit;
    logic w_mem_hit;
    logic w_link_hit;

    assign w_ex_hit  = src_hit(id_ex_dest, rs_addr, rs_used)
                     | src_hit(id_ex_dest, rt_addr, rt_used);
    assign w_mem_hit = src_hit(ex_mem_dest, rs_addr, rs_used)
                     | src_hit(ex_mem_dest, rt_addr, rt_used);

    // A return through the link register right after a link write must wait.
    assign w_link_hit = redirect_type && id_ex_reg_write && (id_ex_dest == RA_REG)
                     && rs_used && (rs_addr == RA_REG) && (RA_REG != 5'd0);

    assign stall = (id_ex_mem_read && w_ex_hit)
                 | (redirect_type && id_ex_reg_write && w_ex_hit)
                 | (redirect_type && ex_mem_mem_read && w_mem_hit)
                 | w_link_hit;

endmodule

`default_nettype wire

// File: rtl/if_id_redirect.sv
// ============================================================================
// Module      : if_id_redirect
// Description : IF/ID pipeline register, ID-stage redirect decode and stall.
//               Optional counters enabled by macro IF_ID_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_redirect
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT,
    parameter logic [4:0]  RA_REG   = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] PC,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        id_ex_mem_read,
    input  logic        id_ex_reg_write,
    input  logic [4:0]  id_ex_dest,
    input  logic        ex_mem_mem_read,
    input  logic [4:0]  ex_mem_dest,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic        Branch,
    output logic        bne,
    output logic        Jump,
    output logic        jal,
    output logic        jr,
    output logic        zero,
    output logic [31:0] shifted,
    output logic [27:0] Jump_address,
    output logic [31:0] jr_address,
    output logic        stall
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] redirect_count
`endif
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic        r_valid;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_rs_used;
    logic        w_rt_used;
    logic        w_redirect_type;
    logic        w_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= NOP_WORD;
            r_pc    <= 32'd0;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_instr <= instruction;
            r_pc    <= PC;
            r_valid <= 1'b1;
        end
    end

    assign if_id_instruction = r_instr;
    assign if_id_pc          = r_pc;
    assign rs_addr           = r_instr[25:21];
    assign rt_addr           = r_instr[20:16];

    assign w_op            = r_instr[31:26];
    assign w_funct         = r_instr[5:0];
    assign w_rs_used       = rs_is_used(w_op);
    assign w_rt_used       = rt_is_used(w_op);
    assign w_redirect_type = is_redirect_type(w_op, w_funct);

    hazard_detect #(
        .RA_REG (RA_REG)
    ) u_hazard_detect (
        .rs_used         (w_rs_used),
        .rt_used         (w_rt_used),
        .rs_addr         (rs_addr),
        .rt_addr         (rt_addr),
        .redirect_type   (w_redirect_type),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_dest      (id_ex_dest),
        .ex_mem_mem_read (ex_mem_mem_read),
        .ex_mem_dest     (ex_mem_dest),
        .stall           (stall)
    );

    assign w_go = r_valid && !stall;

    // Fetch adds PC+4 on top of an already-advanced PC, hence the -4.
    always_comb begin
        Branch       = 1'b0;
        bne          = 1'b0;
        Jump         = 1'b0;
        jal          = 1'b0;
        jr           = 1'b0;
        zero         = 1'b0;
        shifted      = 32'd0;
        Jump_address = 28'd0;
        jr_address   = 32'd0;
        if (w_go) begin
            case (w_op)
                OP_BEQ, OP_BNE: begin
                    Branch  = (w_op == OP_BEQ);
                    bne     = (w_op == OP_BNE);
                    zero    = (rs_data == rt_data);
                    shifted = {{14{r_instr[15]}}, r_instr[15:0], 2'b00} - 32'd4;
                end
                OP_J, OP_JAL: begin
                    Jump         = 1'b1;
                    jal          = (w_op == OP_JAL);
                    Jump_address = {r_instr[25:0], 2'b00};
                end
                OP_RTYPE: begin
                    if (w_funct == FUNCT_JR) begin
                        jr         = 1'b1;
                        jr_address = rs_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IF_ID_PERF_EN
    logic w_taken;

    assign w_taken = (Branch && zero) || (bne && !zero) || Jump || jr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count    <= 32'd0;
            redirect_count <= 32'd0;
        end else begin
            if (stall && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
            if (w_taken && redirect_count != 32'hFFFF_FFFF)
                redirect_count <= redirect_count + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_redirect.sv
// Randomized bench for if_id_redirect against a behavioural pipeline model.
`default_nettype none

module tb_if_id_redirect;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction, PC, rs_data, rt_data;
    logic        id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
    logic [4:0]  id_ex_dest, ex_mem_dest;
    logic [31:0] if_id_instruction, if_id_pc, shifted, jr_address;
    logic [4:0]  rs_addr, rt_addr;
    logic        Branch, bne, Jump, jal, jr, zero, stall;
    logic [27:0] Jump_address;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: contents of the IF/ID register.
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_stall;

    if_id_redirect dut (
        .clk(clk), .reset(reset), .instruction(instruction), .PC(PC),
        .rs_data(rs_data), .rt_data(rt_data),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_reg_write(id_ex_reg_write),
        .id_ex_dest(id_ex_dest), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_dest(ex_mem_dest), .if_id_instruction(if_id_instruction),
        .if_id_pc(if_id_pc), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .Branch(Branch), .bne(bne), .Jump(Jump), .jal(jal), .jr(jr),
        .zero(zero), .shifted(shifted), .Jump_address(Jump_address),
        .jr_address(jr_address), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic depends(input logic [31:0] ins, input logic [4:0] d);
        int op;
        logic u_rs, u_rt;
        op   = int'(ins[31:26]);
        u_rs = !(op == 2 || op == 3 || op == 15);
        u_rt = (op == 0 || op == 4 || op == 5 || op == 43);
        if (d == 5'd0) return 1'b0;
        return (u_rs && d == ins[25:21]) || (u_rt && d == ins[20:16]);
    endfunction

    task automatic check_outputs();
        int op, off;
        logic redir, go;
        logic [31:0] e_shift;
        op    = int'(m_instr[31:26]);
        redir = (op == 4) || (op == 5) || (op == 0 && m_instr[5:0] == 6'd8);
        m_stall = (id_ex_mem_read && depends(m_instr, id_ex_dest))
               || (redir && id_ex_reg_write && depends(m_instr, id_ex_dest))
               || (redir && ex_mem_mem_read && depends(m_instr, ex_mem_dest));
        go    = m_valid && !m_stall;
        off   = $signed(m_instr[15:0]);
        e_shift = 32'(off * 4 - 4);
        check("if_id_instruction", if_id_instruction, m_instr);
        check("if_id_pc", if_id_pc, m_pc);
        check("rs_addr", {27'd0, rs_addr}, {27'd0, m_instr[25:21]});
        check("rt_addr", {27'd0, rt_addr}, {27'd0, m_instr[20:16]});
        check("stall", {31'd0, stall}, {31'd0, m_stall});
        check("Branch", {31'd0, Branch}, {31'd0, go && op == 4});
        check("bne", {31'd0, bne}, {31'd0, go && op == 5});
        check("Jump", {31'd0, Jump}, {31'd0, go && (op == 2 || op == 3)});
        check("jal", {31'd0, jal}, {31'd0, go && op == 3});
        check("jr", {31'd0, jr}, {31'd0, go && op == 0 && m_instr[5:0] == 6'd8});
        check("zero", {31'd0, zero},
              {31'd0, go && (op == 4 || op == 5) && rs_data == rt_data});
        check("shifted", shifted, (go && (op == 4 || op == 5)) ? e_shift : 32'd0);
        check("Jump_address", {4'd0, Jump_address},
              (go && (op == 2 || op == 3)) ? {4'd0, m_instr[25:0], 2'b00} : 32'd0);
        check("jr_address", jr_address,
              (go && op == 0 && m_instr[5:0] == 6'd8) ? rs_data : 32'd0);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic exm, input logic exw, input logic [4:0] exd,
                         input logic mmr, input logic [4:0] mmd);
        instruction = ins; PC = pc; rs_data = rsd; rt_data = rtd;
        id_ex_mem_read = exm; id_ex_reg_write = exw; id_ex_dest = exd;
        ex_mem_mem_read = mmr; ex_mem_dest = mmd;
        #1;
        check_outputs();
    endtask

    // Advance one clock; the model loads IF/ID only when not stalled.
    task automatic step();
        logic hold;
        hold = m_stall;
        @(posedge clk);
        #1;
        if (!hold) begin
            m_instr = instruction;
            m_pc    = PC;
            m_valid = 1'b1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [9];
        logic [31:0] w;
        ops = '{6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd15, 6'd43, 6'd35};
        w = $urandom;
        w[31:26] = ops[$urandom_range(8)];
        w[25:21] = ($urandom_range(4) == 0) ? 5'd31 : 5'($urandom_range(4));
        w[20:16] = 5'($urandom_range(4));
        if (w[31:26] == 6'd0 && $urandom_range(1) == 1) w[5:0] = 6'd8;
        return w;
    endfunction

    initial begin
        m_stall = 1'b0;
        drive(32'h2002_0005, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        apply_reset();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        step();
        check("first_load", if_id_instruction, 32'h2002_0005);

        // beq $1,$2,+3 at PC 0x10
        drive(32'h1022_0003, 32'h10, 32'd7, 32'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        drive(32'h0800_0040, 32'h14, 32'd7, 32'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        check("beq_target", 32'h14 + 32'd4 + shifted, 32'h20);
        step();
        drive(32'h0C00_0040, 32'h18, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        check("j_addr", {4'd0, Jump_address}, 32'h100);
        step();
        drive(32'h0065_2020, 32'h1C, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        check("jal_flag", {31'd0, jal}, 32'd1);
        step();
        // lw $3 in EX, add $4,$3,$5 in ID
        drive(32'h03E0_0008, 32'h20, 32'd0, 32'd0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
        check("load_use_stall", {31'd0, stall}, 32'd1);
        step();
        drive(32'h03E0_0008, 32'h20, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        check("load_use_held", if_id_instruction, 32'h0065_2020);
        step();
        // jr $31 with $31 being written in EX
        drive(32'h2002_0005, 32'h24, 32'h400, 32'd0, 1'b0, 1'b1, 5'd31, 1'b0, 5'd0);
        check("jr_stall", {31'd0, stall}, 32'd1);
        drive(32'h2002_0005, 32'h24, 32'h400, 32'd0, 1'b0, 1'b0, 5'd31, 1'b0, 5'd0);
        check("jr_go", jr_address, 32'h400);
        step();
        // $0 dependency never stalls
        drive(32'h0, 32'h28, 32'd0, 32'd0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0);
        check("zero_reg_nostall", {31'd0, stall}, 32'd0);
        step();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d = ($urandom_range(1) == 1) ? 32'($urandom_range(3)) : $urandom;
            drive(rand_instr(), $urandom, d,
                  ($urandom_range(1) == 1) ? d : $urandom,
                  $urandom_range(3) == 0, $urandom_range(1) == 1,
                  5'($urandom_range(5)), $urandom_range(3) == 0,
                  5'($urandom_range(5)));
            if (i == 200) begin
                #2;
                apply_reset();
                @(negedge clk);
                reset = 1'b0;
                #1;
                check_outputs();
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
